mem_access_unit: RTL and testbench

Load/store alignment stage between the MIPS datapath and the word-wide data memory. It converts byte, halfword and word accesses from the datapath into aligned 32-bit word accesses, and extracts plus sign- or zero-extends load data. Sub-word stores are done as a two-cycle read-modify-write with a pipeline stall. Misaligned or out-of-range accesses are suppressed and latched in a sticky fault register.

---
 rtl/mem_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store alignment stage between the datapath and a
// word-wide data memory. Loads pick a lane and sign/zero-extend it. Word
// stores go straight through. Sub-word stores are a two-cycle
// read-modify-write that stalls the datapath for one cycle. Illegal accesses
// are suppressed and recorded in a sticky fault register.
//
// Build option: define MAU_SUBWORD_EN for byte/halfword support. Without it,
// every access is a word access, Address_i[1:0] is ignored and the merge FSM
// is not built.
//
// Handshake: no valid/ready pair. A request is MemRead_i/MemWrite_i. While
// Stall_o is 1 the datapath holds every input stable. The request is
// complete at the first rising edge where Stall_o is 0.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR    = 32'h10010000,
  parameter int unsigned MEMORY_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  Size_i,
  input  logic        Unsigned_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Stall_o,
  output logic        Fault_o,
  output logic [31:0] Fault_Addr_o,
  output logic [31:0] Mem_Address_o,
  output logic [31:0] Mem_Write_Data_o,
  output logic        Mem_Write_Enable_o,
  input  logic [31:0] Mem_Read_Data_i,
  output logic        o_dbg_state
);

  // One past the last legal byte address. It is 33 bits wide so the end of
  // the segment cannot wrap around.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEMORY_DEPTH);

  logic        w_in_range;
  logic        w_legal;
  logic        w_fault_evt;
  logic [31:0] w_aligned_addr;
  logic        r_fault;
  logic [31:0] r_fault_addr;

  assign w_in_range     = ({1'b0, Address_i} >= {1'b0, BASE_ADDR}) &&
                          ({1'b0, Address_i} <  END_ADDR);
  assign w_aligned_addr = {Address_i[31:2], 2'b00};

`ifdef MAU_SUBWORD_EN

  typedef enum logic {S_IDLE = 1'b0, S_MERGE = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_merge;
  logic [31:0] r_addr;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_aligned;
  logic        w_sub_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_merge;

  // Size 11 falls through to word.
  assign w_is_byte   = (Size_i == 2'b00);
  assign w_is_half   = (Size_i == 2'b01);
  assign w_aligned   = w_is_byte ? 1'b1 :
                       w_is_half ? ~Address_i[0] : (Address_i[1:0] == 2'b00);
  assign w_legal     = w_in_range & w_aligned;
  assign w_sub_store = MemWrite_i & w_legal & (w_is_byte | w_is_half) &
                       (r_state == S_IDLE);
  // While the FSM is in MERGE the held request was already judged legal.
  assign w_fault_evt = (MemRead_i | MemWrite_i) & ~w_legal & (r_state == S_IDLE);
  assign o_dbg_state = (r_state == S_MERGE);

  // Lane extraction and extension of the load data.
  always_comb begin
    w_byte = Mem_Read_Data_i[7:0];
    case (Address_i[1:0])
      2'd0: w_byte = Mem_Read_Data_i[7:0];
      2'd1: w_byte = Mem_Read_Data_i[15:8];
      2'd2: w_byte = Mem_Read_Data_i[23:16];
      2'd3: w_byte = Mem_Read_Data_i[31:24];
      default: w_byte = Mem_Read_Data_i[7:0];
    endcase
    w_half = Address_i[1] ? Mem_Read_Data_i[31:16] : Mem_Read_Data_i[15:0];
    if (w_is_byte)
      Read_Data_o = {{24{~Unsigned_i & w_byte[7]}}, w_byte};
    else if (w_is_half)
      Read_Data_o = {{16{~Unsigned_i & w_half[15]}}, w_half};
    else
      Read_Data_o = Mem_Read_Data_i;
  end

  // Put the store data into its lane of the word just read.
  always_comb begin
    w_merge = Mem_Read_Data_i;
    if (w_is_byte) begin
      case (Address_i[1:0])
        2'd0: w_merge[7:0]   = Write_Data_i[7:0];
        2'd1: w_merge[15:8]  = Write_Data_i[7:0];
        2'd2: w_merge[23:16] = Write_Data_i[7:0];
        2'd3: w_merge[31:24] = Write_Data_i[7:0];
        default: w_merge = Mem_Read_Data_i;
      endcase
    end else if (Address_i[1]) begin
      w_merge[31:16] = Write_Data_i[15:0];
    end else begin
      w_merge[15:0] = Write_Data_i[15:0];
    end
  end

  // Read-modify-write FSM. It captures the merged word and address in IDLE
  // and writes them back in MERGE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_merge <= 32'h0;
      r_addr  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sub_store) begin
            r_merge <= w_merge;
            r_addr  <= w_aligned_addr;
            r_state <= S_MERGE;
          end
        end
        S_MERGE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory-side drive. Reset blocks every write, including one in MERGE.
  always_comb begin
    Mem_Address_o      = w_aligned_addr;
    Mem_Write_Data_o   = Write_Data_i;
    Mem_Write_Enable_o = 1'b0;
    Stall_o            = 1'b0;
    if (!reset) begin
      if (r_state == S_MERGE) begin
        Mem_Address_o      = r_addr;
        Mem_Write_Data_o   = r_merge;
        Mem_Write_Enable_o = 1'b1;
      end else if (MemWrite_i && w_legal) begin
        if (w_is_byte || w_is_half)
          Stall_o = 1'b1;
        else
          Mem_Write_Enable_o = 1'b1;
      end
    end
  end

`else

  logic w_unused_cfg;

  // Every access is a word access. Size and extension inputs have no effect.
  assign w_unused_cfg       = ^{Size_i, Unsigned_i};
  assign w_legal            = w_in_range;
  assign w_fault_evt        = (MemRead_i | MemWrite_i) & ~w_legal;
  assign o_dbg_state        = 1'b0;
  assign Read_Data_o        = Mem_Read_Data_i;
  assign Stall_o            = 1'b0;
  assign Mem_Address_o      = w_aligned_addr;
  assign Mem_Write_Data_o   = Write_Data_i;
  assign Mem_Write_Enable_o = MemWrite_i & w_legal & ~reset;

`endif

  // Sticky fault flag. The address is captured only for the first fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'h0;
    end else if (w_fault_evt) begin
      r_fault <= 1'b1;
      if (!r_fault)
        r_fault_addr <= Address_i;
    end
  end

  assign Fault_o      = r_fault;
  assign Fault_Addr_o = r_fault_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_i, MemWrite_i, Unsigned_i;
  logic [1:0]  Size_i;
  logic [31:0] Address_i, Write_Data_i;
  logic [31:0] Read_Data_o, Fault_Addr_o, Mem_Address_o, Mem_Write_Data_o;
  logic        Stall_o, Fault_o, Mem_Write_Enable_o, o_dbg_state;
  logic [31:0] Mem_Read_Data_i;

  logic [31:0] dut_mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] rd_off;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.BASE_ADDR(BASE), .MEMORY_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Size_i(Size_i), .Unsigned_i(Unsigned_i),
    .Address_i(Address_i), .Write_Data_i(Write_Data_i),
    .Read_Data_o(Read_Data_o), .Stall_o(Stall_o),
    .Fault_o(Fault_o), .Fault_Addr_o(Fault_Addr_o),
    .Mem_Address_o(Mem_Address_o), .Mem_Write_Data_o(Mem_Write_Data_o),
    .Mem_Write_Enable_o(Mem_Write_Enable_o), .Mem_Read_Data_i(Mem_Read_Data_i),
    .o_dbg_state(o_dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Data memory: combinational read, write at the rising edge
  always_comb begin
    rd_off = Mem_Address_o - BASE;
    Mem_Read_Data_i = 32'h0;
    if (Mem_Address_o >= BASE && Mem_Address_o < BASE + 4 * DEPTH)
      Mem_Read_Data_i = dut_mem[rd_off[7:2]];
  end

  always @(posedge clk) begin
    if (Mem_Write_Enable_o && Mem_Address_o >= BASE && Mem_Address_o < BASE + 4 * DEPTH)
      dut_mem[rd_off[7:2]] <= Mem_Write_Data_o;
  end

  // Reference model, computed from byte lanes and masks
  function automatic int nbytes(input logic [1:0] size);
`ifdef MAU_SUBWORD_EN
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`else
    return 4;
`endif
  endfunction

  function automatic int word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'(off[7:2]);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    int n, w;
    logic [31:0] val, mask;
    n = nbytes(size);
    if (n == 4) return word;
    w = 8 * n;
    mask = (32'h1 << w) - 32'h1;
    val = (word >> (8 * int'(addr[1:0]))) & mask;
    if (!uns && val[w-1]) val = val | ~mask;
    return val;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] data);
    int n, sh;
    logic [31:0] mask;
    n = nbytes(size);
    if (n == 4) return data;
    sh = 8 * int'(addr[1:0]);
    mask = ((32'h1 << (8 * n)) - 32'h1) << sh;
    return (old & ~mask) | ((data << sh) & mask);
  endfunction

  // Driver tasks
  task automatic drive_idle();
    MemRead_i = 1'b0; MemWrite_i = 1'b0; Size_i = 2'b10; Unsigned_i = 1'b0;
    Address_i = BASE; Write_Data_i = 32'h0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input string tag);
    logic [31:0] exp_w;
    int idx;
    idx = word_idx(addr);
    exp_w = model_store(ref_mem[idx], addr, size, data);
    @(negedge clk);
    MemWrite_i = 1'b1; MemRead_i = 1'b0; Address_i = addr; Write_Data_i = data; Size_i = size;
    #2;
    if (nbytes(size) < 4) begin
      n_checks++;
      if (Stall_o !== 1'b1 || Mem_Write_Enable_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s read_cycle: stall=%b we=%b, want stall=1 we=0", tag, Stall_o, Mem_Write_Enable_o);
      end
      @(negedge clk);
      #2;
    end
    n_checks++;
    if (Stall_o !== 1'b0 || Mem_Write_Enable_o !== 1'b1 ||
        Mem_Address_o !== {addr[31:2], 2'b00} || Mem_Write_Data_o !== exp_w) begin
      n_fail++;
      $display("FAIL %s write_cycle: stall=%b we=%b addr=%h data=%h, want 0 1 %h %h",
               tag, Stall_o, Mem_Write_Enable_o, Mem_Address_o, Mem_Write_Data_o,
               {addr[31:2], 2'b00}, exp_w);
    end
    @(posedge clk);
    #1;
    drive_idle();
    ref_mem[idx] = exp_w;
    n_checks++;
    if (dut_mem[idx] !== exp_w) begin
      n_fail++;
      $display("FAIL %s mem_word: got %h want %h", tag, dut_mem[idx], exp_w);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input string tag, output logic [31:0] got);
    logic [31:0] exp_v;
    exp_v = model_load(ref_mem[word_idx(addr)], addr, size, uns);
    @(negedge clk);
    MemRead_i = 1'b1; MemWrite_i = 1'b0; Address_i = addr; Size_i = size; Unsigned_i = uns;
    #2;
    got = Read_Data_o;
    n_checks++;
    if (Read_Data_o !== exp_v || Stall_o !== 1'b0 || Mem_Write_Enable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s load: data=%h stall=%b we=%b, want %h 0 0",
               tag, Read_Data_o, Stall_o, Mem_Write_Enable_o, exp_v);
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic do_bad_access(input logic [31:0] addr, input logic [1:0] size,
                               input logic is_store, input string tag);
    @(negedge clk);
    MemWrite_i = is_store; MemRead_i = ~is_store; Address_i = addr;
    Size_i = size; Write_Data_i = 32'h5A5A5A5A;
    #2;
    n_checks++;
    if (Mem_Write_Enable_o !== 1'b0 || Stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s suppress: we=%b stall=%b, want 0 0", tag, Mem_Write_Enable_o, Stall_o);
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic check_mem_all(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dut_mem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s mem_image: %0d words differ, want 0", tag, bad);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    dut_mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    MemWrite_i = 1'b1; Address_i = BASE + 32'h10; Write_Data_i = 32'h12345678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    n_checks++;
    if (Stall_o !== 1'b0 || Mem_Write_Enable_o !== 1'b0 || Fault_o !== 1'b0 ||
        Fault_Addr_o !== 32'h0 || o_dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: stall=%b we=%b fault=%b faddr=%h st=%b, want all 0",
               Stall_o, Mem_Write_Enable_o, Fault_o, Fault_Addr_o, o_dbg_state);
    end
    reset = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    check_mem_all("reset_no_write");
  endtask

  task automatic test_word_store();
    do_store(32'h10010004, 32'hDEADBEEF, 2'b10, "sw_basic");
    do_store(32'h10010010, 32'h0BADF00D, 2'b11, "sw_size3");
  endtask

  task automatic test_subword_store();
    set_word(2, 32'h11223344);
    do_store(32'h1001000A, 32'h000000AB, 2'b00, "sb_lane2");
    n_checks++;
`ifdef MAU_SUBWORD_EN
    if (dut_mem[2] !== 32'h11AB3344) begin
      n_fail++;
      $display("FAIL sb_const: got %h want 11ab3344", dut_mem[2]);
    end
`else
    if (dut_mem[2] !== 32'h000000AB || Fault_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_as_word: got %h fault=%b want 000000ab 0", dut_mem[2], Fault_o);
    end
`endif
  endtask

  task automatic test_loads();
    logic [31:0] got;
    set_word(0, 32'h80FF7F01);
`ifdef MAU_SUBWORD_EN
    do_load(32'h10010003, 2'b00, 1'b0, "lb", got);
    n_checks++;
    if (got !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_const: got %h want ffffff80", got); end
    do_load(32'h10010003, 2'b00, 1'b1, "lbu", got);
    n_checks++;
    if (got !== 32'h00000080) begin n_fail++; $display("FAIL lbu_const: got %h want 00000080", got); end
    do_load(32'h10010002, 2'b01, 1'b0, "lh", got);
    n_checks++;
    if (got !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_const: got %h want ffff80ff", got); end
    do_load(32'h10010000, 2'b01, 1'b1, "lhu", got);
    n_checks++;
    if (got !== 32'h00007F01) begin n_fail++; $display("FAIL lhu_const: got %h want 00007f01", got); end
`else
    do_load(32'h10010003, 2'b00, 1'b0, "lb_as_lw", got);
    n_checks++;
    if (got !== 32'h80FF7F01) begin n_fail++; $display("FAIL lw_const: got %h want 80ff7f01", got); end
`endif
    do_load(32'h10010000, 2'b10, 1'b0, "lw", got);
  endtask

  task automatic test_back_to_back();
    set_word(8, 32'hA0A1A2A3);
    do_store(32'h10010021, 32'hFFFFFF5C, 2'b00, "b2b_sb");
    do_store(32'h10010022, 32'hFFFF9876, 2'b01, "b2b_sh");
    n_checks++;
`ifdef MAU_SUBWORD_EN
    if (dut_mem[8] !== 32'h98765CA3) begin
      n_fail++;
      $display("FAIL b2b_const: got %h want 98765ca3", dut_mem[8]);
    end
`else
    if (dut_mem[8] !== 32'hFFFF9876) begin
      n_fail++;
      $display("FAIL b2b_const: got %h want ffff9876", dut_mem[8]);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] addr, got;
    logic [1:0]  size;
    int lane;
    for (int i = 0; i < 80; i++) begin
      size = 2'($urandom_range(0, 3));
      lane = $urandom_range(0, 3);
`ifdef MAU_SUBWORD_EN
      if (size == 2'b01) lane = lane & 2;
      else if (size[1]) lane = 0;
`endif
      addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'(lane);
      if ($urandom_range(0, 1) == 1)
        do_store(addr, $urandom, size, "rnd_store");
      else
        do_load(addr, size, 1'($urandom_range(0, 1)), "rnd_load", got);
    end
    check_mem_all("rnd_image");
    n_checks++;
    if (Fault_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_no_fault: fault=%b want 0", Fault_o);
    end
  endtask

`ifdef MAU_SUBWORD_EN
  task automatic test_reset_merge();
    set_word(3, 32'hCAFEF00D);
    @(negedge clk);
    MemWrite_i = 1'b1; Address_i = 32'h1001000E; Write_Data_i = 32'h00005555; Size_i = 2'b01;
    #2;
    n_checks++;
    if (Stall_o !== 1'b1) begin n_fail++; $display("FAIL rstm_stall: got %b want 1", Stall_o); end
    @(negedge clk);
    reset = 1'b1;
    #2;
    n_checks++;
    if (Mem_Write_Enable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstm_we: got %b want 0", Mem_Write_Enable_o);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #2;
    n_checks++;
    if (Stall_o !== 1'b0 || o_dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL rstm_idle: stall=%b st=%b want 0 0", Stall_o, o_dbg_state);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_mem[3] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL rstm_mem: got %h want cafef00d", dut_mem[3]);
    end
  endtask
`endif

  task automatic test_fault();
    logic [31:0] first_bad;
`ifdef MAU_SUBWORD_EN
    first_bad = 32'h10010006;
    do_bad_access(32'h10010006, 2'b10, 1'b1, "flt_misalign");
`else
    first_bad = 32'h10010200;
    do_store(32'h10010006, 32'h600D600D, 2'b10, "flt_low_bits_ignored");
    n_checks++;
    if (Fault_o !== 1'b0) begin n_fail++; $display("FAIL flt_none: fault=%b want 0", Fault_o); end
`endif
    do_bad_access(32'h10010200, 2'b10, 1'b1, "flt_range");
    n_checks++;
    if (Fault_o !== 1'b1 || Fault_Addr_o !== first_bad) begin
      n_fail++;
      $display("FAIL flt_first: fault=%b addr=%h want 1 %h", Fault_o, Fault_Addr_o, first_bad);
    end
    do_bad_access(32'h0FFFFFFC, 2'b10, 1'b0, "flt_below");
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (Fault_o !== 1'b1 || Fault_Addr_o !== first_bad) begin
      n_fail++;
      $display("FAIL flt_sticky: fault=%b addr=%h want 1 %h", Fault_o, Fault_Addr_o, first_bad);
    end
    check_mem_all("flt_image");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    n_checks++;
    if (Fault_o !== 1'b0 || Fault_Addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL flt_clear: fault=%b addr=%h want 0 0", Fault_o, Fault_Addr_o);
    end
  endtask

  // Main sequence and final report
  initial begin
    reset = 1'b1;
    drive_idle();
    for (int i = 0; i < DEPTH; i++) set_word(i, $urandom);
    test_reset();
    test_word_store();
    test_subword_store();
    test_loads();
    test_back_to_back();
    test_random();
`ifdef MAU_SUBWORD_EN
    test_reset_merge();
`endif
    test_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
